// File: rtl/lmsm_pkg.sv
// Shared types and widths for the LM/SM micro-op sequencer.
package lmsm_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int LIST_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic              is_sm;
        logic [REG_W-1:0]  rsel;
        logic [DATA_W-1:0] addr;
        logic              last;
    } uop_t;

endpackage

// File: rtl/lmsm_sequencer_prienc.sv
// Lowest-set-bit priority encoder over the remaining register list.
module lmsm_prienc
    import lmsm_pkg::*;
(
    input  logic [LIST_W-1:0] i_list,
    output logic [REG_W-1:0]  o_index,
    output logic              o_any,
    output logic [LIST_W-1:0] o_onehot
);

    // Scan from the top so the lowest set bit is the final assignment.
    always_comb begin
        o_index = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (i_list[i]) begin
                o_index = REG_W'(i);
            end
        end
    end

    assign o_any    = |i_list;
    assign o_onehot = i_list & (~i_list + LIST_W'(1));

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM micro-op sequencer: expands a register bitmap into one load/store
// micro-op per set bit at consecutive addresses, stalling decode meanwhile.
// Optional build macro: LMSM_STATS_EN adds o_uop_count (saturating count of
// accepted micro-ops, cleared only by reset).
//
// state | meaning
// IDLE  | waiting for an LM/SM from decode
// RUN   | issuing micro-ops from the latched list
module lmsm_sequencer
    import lmsm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_is_sm,
    input  logic [LIST_W-1:0] i_reg_list,
    input  logic [DATA_W-1:0] i_base_addr,
    input  logic              i_ex_ready,
    input  logic              i_flush,
    output logic              o_stall_req,
    output logic              o_uop_valid,
    output logic              o_uop_is_sm,
    output logic [REG_W-1:0]  o_uop_reg,
    output logic [DATA_W-1:0] o_uop_addr,
    output logic              o_uop_last,
    output logic              o_done
`ifdef LMSM_STATS_EN
    ,
    output logic [15:0]       o_uop_count
`endif
);

    localparam logic [0:0] S_IDLE = 1'(ST_IDLE);
    localparam logic [0:0] S_RUN  = 1'(ST_RUN);

    logic [0:0]        r_state;
    logic              r_is_sm;
    logic [LIST_W-1:0] r_list;
    logic [DATA_W-1:0] r_addr;
    logic              r_done;

    logic [REG_W-1:0]  w_idx;
    logic              w_any;
    logic [LIST_W-1:0] w_onehot;
    logic              w_run;
    logic              w_last;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_start_empty;
    uop_t              w_uop;

    lmsm_prienc u_prienc (
        .i_list   (r_list),
        .o_index  (w_idx),
        .o_any    (w_any),
        .o_onehot (w_onehot)
    );

    assign w_run         = (r_state == S_RUN);
    assign w_last        = w_run & w_any & (r_list == w_onehot);
    // Flush outranks completion, so a flushed micro-op is never accepted.
    assign w_accept      = w_run & i_ex_ready & ~i_flush;
    assign w_start_ok    = ~w_run & i_start & ~i_flush & (|i_reg_list);
    assign w_start_empty = ~w_run & i_start & ~i_flush & ~(|i_reg_list);

    // Micro-op fields are zeroed outside RUN so idle outputs read as 0.
    assign w_uop = '{is_sm: r_is_sm & w_run,
                     rsel:  w_run ? w_idx  : '0,
                     addr:  w_run ? r_addr : '0,
                     last:  w_last};

    assign o_uop_valid = w_run;
    assign o_uop_is_sm = w_uop.is_sm;
    assign o_uop_reg   = w_uop.rsel;
    assign o_uop_addr  = w_uop.addr;
    assign o_uop_last  = w_uop.last;
    assign o_done      = r_done;
    assign o_stall_req = (w_run & ~(w_last & i_ex_ready))
                       | (~w_run & i_start & (|i_reg_list));

    // Sequencer state, latched instruction and remaining list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_is_sm <= 1'b0;
            r_list  <= '0;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_flush) begin
                r_state <= S_IDLE;
                r_list  <= '0;
            end else if (w_start_ok) begin
                r_state <= S_RUN;
                r_is_sm <= i_is_sm;
                r_list  <= i_reg_list;
                r_addr  <= i_base_addr;
            end else if (w_start_empty) begin
                r_done <= 1'b1;
            end else if (w_accept) begin
                r_list <= r_list & ~w_onehot;
                r_addr <= r_addr + DATA_W'(1);
                if (w_last) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

`ifdef LMSM_STATS_EN
    logic [15:0] r_uop_count;

    // Saturating count of accepted micro-ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_uop_count <= '0;
        end else if (w_accept && (r_uop_count != 16'hFFFF)) begin
            r_uop_count <= r_uop_count + 16'd1;
        end
    end

    assign o_uop_count = r_uop_count;
`endif

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Micro-op sequencer for the load-multiple (LM) and store-multiple (SM) instructions of the 8-register, 16-bit RISC pipeline. It accepts an LM/SM from decode and expands its 8-bit register list into one single-register load/store micro-op per set bit, with consecutive memory addresses. It holds fetch/decode stalled until the list is exhausted. It sits between ID and the register-read/EX stage and feeds the micro-op type flags that the load/store forwarding logic consumes.

## Interface
- DATA_W, 16, address/data width
- REG_W, 3, register index width
- LIST_W, 8, register-list width (2**REG_W)

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  decode presents a valid LM/SM this cycle
- is_sm  in  1  1 = SM, 0 = LM; sampled with start
- reg_list  in  LIST_W  register bitmap, bit i = Ri; sampled with start
- base_addr  in  DATA_W  value of RA, the first transfer address; sampled with start
- ex_ready  in  1  downstream accepts the current micro-op this cycle
- flush  in  1  squash the in-flight LM/SM (branch/jump resolved taken)
- stall_req  out  1  hold PC and IF/ID
- uop_valid  out  1  micro-op on uop_* is valid
- uop_is_sm  out  1  micro-op is a store (SW-type); 0 = load (LW-type)
- uop_reg  out  REG_W  destination (LM) or source (SM) register
- uop_addr  out  DATA_W  memory address of this micro-op
- uop_last  out  1  current micro-op is the final one of the list
- done  out  1  one-cycle pulse after the final micro-op is accepted

## Operation
- States: IDLE, RUN.
- IDLE, start=1, reg_list!=0:
  - latch is_sm, reg_list and base_addr.
  - go to RUN.
- IDLE, start=1, reg_list==0:
  - stay in IDLE and issue no micro-ops.
  - pulse done on the next cycle.
- start while in RUN is ignored. Decode is held by stall_req, so start stays asserted until the instruction is accepted.
- In RUN, uop_valid=1 every cycle. The micro-op is built from:
  - uop_reg = index of the lowest set bit of the remaining list (R0 first).
  - uop_addr = latched base plus the number of micro-ops already accepted, arithmetic modulo 2^DATA_W. 0xFFFF + 1 wraps to 0x0000.
  - uop_last = remaining list has exactly one set bit.
- Handshake: a micro-op completes on a cycle with uop_valid & ex_ready.
  - On completion, clear that list bit and increment the address.
  - If ex_ready=0, all uop_* outputs hold stable.
- After the last accepted micro-op, go to IDLE; done=1 on the following cycle.
- stall_req:
  - asserted while in RUN, except on the cycle where uop_last & ex_ready.
  - also asserted combinationally in IDLE when start=1 and reg_list!=0.
- flush has priority over every other event, including completion of the last micro-op.
  - Next edge: state goes to IDLE and the remaining list is cleared.
  - done is not pulsed and no further uop_valid is produced.
  - In IDLE, flush also suppresses acceptance of start.
- Reset value of every output is 0. Registers clear to 0 and state to IDLE on rst_n low, regardless of clk. Reset mid-sequence abandons the list with no done.

## Timing
- Latency: start accepted at edge N → first uop_valid in cycle N+1.
- Throughput: one micro-op per cycle while ex_ready=1. A list with k set bits takes k cycles plus one per ex_ready=0 cycle.
- done is asserted in the cycle after the last acceptance; stall_req is already low in that cycle.
- A back-to-back start in the same cycle that done is high is accepted.
- All outputs are registered except stall_req, uop_last and done-derived logic, which are decoded from registered state.

## Configuration
- LMSM_STATS_EN defined:
  - adds output port uop_count, 16 bits.
  - counts accepted micro-ops, saturating at 0xFFFF.
  - cleared only by rst_n.
- LMSM_STATS_EN undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Package lmsm_pkg holds:
  - state enum {IDLE, RUN}.
  - REG_W and LIST_W constants.
  - micro-op struct (is_sm, reg, addr, last).
- Sub-module lmsm_prienc: LIST_W-bit lowest-set-bit priority encoder. Outputs index (REG_W), any, and onehot (bit to clear).

## Test plan
- LM, list 0x85, base 0x0100, ex_ready=1 → micro-ops (R0, 0x0100), (R2, 0x0101), (R7, 0x0102, last). done on the 4th cycle after start. stall_req high for 3 cycles.
- SM, list 0x0A, base 0x0200, ex_ready low on the 2nd cycle → (R1, 0x0200) accepted, (R3, 0x0201) held 2 cycles then accepted. uop_is_sm=1 throughout.
- Start with list 0x00 → no uop_valid; done pulses once on the next cycle.
- LM, list 0xFF, base 0xFFFE → addresses 0xFFFE, 0xFFFF, 0x0000…0x0005. Flush asserted after the 3rd acceptance → IDLE next cycle, no done.
- rst_n low during RUN → all outputs 0 immediately. A fresh start after release issues correctly.
- With LMSM_STATS_EN: two LMs with lists 0x03 and 0x10 → uop_count=3.
